// File: rtl/game_physics_engine_pkg.sv
// Shared constants, state codes and small helpers for the dino game physics stage.
// Screen geometry is in pixels; all positions are unsigned bytes.
package game_physics_engine_pkg;

   typedef logic [7:0] ubyte;

   typedef enum logic [3:0] {
      GAME_MENU    = 4'd0,
      GAME_RUNNING = 4'd1,
      GAME_PAUSE   = 4'd2,
      GAME_OVER    = 4'd3
   } game_state_e;

   localparam ubyte X_MAX      = 8'd159;
   localparam ubyte Y_MAX      = 8'd119;
   localparam ubyte GROUND_TOP = 8'd100;
   localparam ubyte DINO_H     = 8'd10;
   localparam ubyte DINO_X     = 8'd20;
   localparam ubyte DINO_W     = 8'd8;
   localparam ubyte OBS_W      = 8'd6;
   localparam ubyte MIN_OBS_H  = 8'd6;
   localparam ubyte MAX_OBS_H  = 8'd14;
   localparam ubyte DINO_Y0    = 8'd90;
   localparam ubyte OBS1_X0    = 8'd120;
   localparam ubyte OBS2_X0    = 8'd254;

   // Respawn column: at least 160+random, at least 40 px behind the other obstacle.
   function automatic ubyte respawn_x(input logic [5:0] rnd, input ubyte other);
      logic [8:0] w_base;
      logic [8:0] w_gap;
      logic [8:0] w_max;
      w_base = 9'd160 + {3'd0, rnd};
      w_gap  = {1'b0, other} + 9'd40;
      w_max  = (w_base > w_gap) ? w_base : w_gap;
      return (w_max > 9'd255) ? 8'd255 : w_max[7:0];
   endfunction

   function automatic logic collides(input ubyte obs_x, input ubyte obs_h, input ubyte dino_y);
      return (obs_x < (DINO_X + DINO_W)) &&
             (({1'b0, obs_x} + {1'b0, OBS_W}) > {1'b0, DINO_X}) &&
             ((dino_y + DINO_H) > (GROUND_TOP - obs_h));
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

endpackage

// File: rtl/game_physics_engine_if.sv
// Button inputs and per-frame game state outputs between the physics stage and its neighbours.
interface game_physics_engine_if;
   logic        btnJump;
   logic        btnPause;
   logic        frameClk;
   logic [3:0]  gameState;
   logic [7:0]  dinoY;
   logic [7:0]  obs1X;
   logic [7:0]  obs1H;
   logic [7:0]  obs2X;
   logic [7:0]  obs2H;
   logic [15:0] score;

   modport master (output btnJump, btnPause,
                   input  frameClk, gameState, dinoY, obs1X, obs1H, obs2X, obs2H, score);
   modport slave  (input  btnJump, btnPause,
                   output frameClk, gameState, dinoY, obs1X, obs1H, obs2X, obs2H, score);
endinterface

// File: rtl/game_frame_divider.sv
// Free-running frame divider: counts 0..FRAME_DIV-1 and flags the last count.
module game_frame_divider #(
   parameter int FRAME_DIV = 833333
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);
   localparam int CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

   logic [CW-1:0] r_count;

   // Frame counter with wrap on the last count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   assign o_tick = (r_count == LAST);
endmodule

// File: rtl/game_physics_engine.sv
// Game-state FSM, dino jump physics, obstacle scroll/respawn, collision and score.
// Everything except the button edge detectors advances only on the frame tick.
module game_physics_engine
   import game_physics_engine_pkg::*;
#(
   parameter int          FRAME_DIV    = 833333,
   parameter int          JUMP_V0      = 6,
   parameter int          GRAVITY      = 1,
   parameter int          SCROLL_SPEED = 2,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input logic                  clk,
   input logic                  reset,
   game_physics_engine_if.slave bus
);
   localparam logic signed [7:0] JUMP_VEL = 8'(-JUMP_V0);
   localparam logic signed [7:0] GRAV     = 8'(GRAVITY);
   localparam ubyte              SCROLL   = 8'(SCROLL_SPEED);

   game_state_e       r_state, w_state_n;
   logic              r_frame_clk, r_jump_d, r_pause_d, r_jump_req, r_pause_req;
   ubyte              r_dino_y, r_obs1_x, r_obs1_h, r_obs2_x, r_obs2_h;
   logic signed [7:0] r_vel;
   logic [15:0]       r_score, r_lfsr;

   logic              w_tick, w_jump_rise, w_pause_rise, w_on_ground, w_airborne, w_hit;
   logic signed [7:0] w_vel_eff, w_vel_phys, w_vel_n;
   logic signed [8:0] w_y_sum;
   ubyte              w_dino_y_phys, w_obs1_x_phys, w_obs1_h_phys, w_obs2_x_phys, w_obs2_h_phys;
   ubyte              w_dino_y_n, w_obs1_x_n, w_obs1_h_n, w_obs2_x_n, w_obs2_h_n;
   logic [15:0]       w_score_n, w_lfsr_n;

   game_frame_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   assign w_jump_rise  = bus.btnJump  & ~r_jump_d;
   assign w_pause_rise = bus.btnPause & ~r_pause_d;

   assign w_on_ground = (r_dino_y == DINO_Y0) && (r_vel == 8'sd0);
   assign w_vel_eff   = (r_jump_req && w_on_ground) ? JUMP_VEL : r_vel;
   assign w_airborne  = (r_dino_y != DINO_Y0) || (w_vel_eff != 8'sd0);
   assign w_y_sum     = $signed({1'b0, r_dino_y}) + {w_vel_eff[7], w_vel_eff};

   // Candidate dino position/velocity for a RUNNING tick
   always_comb begin
      w_dino_y_phys = r_dino_y;
      w_vel_phys    = r_vel;
      if (w_airborne) begin
         if (w_y_sum >= $signed({1'b0, DINO_Y0})) begin
            w_dino_y_phys = DINO_Y0;
            w_vel_phys    = 8'sd0;
         end else if (w_y_sum < 9'sd0) begin
            w_dino_y_phys = 8'd0;
            w_vel_phys    = w_vel_eff + GRAV;
         end else begin
            w_dino_y_phys = w_y_sum[7:0];
            w_vel_phys    = w_vel_eff + GRAV;
         end
      end else begin
         w_dino_y_phys = r_dino_y;
         w_vel_phys    = r_vel;
      end
   end

   // Obstacle scroll; obs2 spaces itself from obs1's already-updated column
   always_comb begin
      w_obs1_x_phys = r_obs1_x - SCROLL;
      w_obs1_h_phys = r_obs1_h;
      w_obs2_x_phys = r_obs2_x - SCROLL;
      w_obs2_h_phys = r_obs2_h;
      if (r_obs1_x < SCROLL) begin
         w_obs1_x_phys = respawn_x(r_lfsr[5:0], r_obs2_x);
         w_obs1_h_phys = MIN_OBS_H + {5'd0, r_lfsr[2:0]};
      end else begin
         w_obs1_h_phys = r_obs1_h;
      end
      if (r_obs2_x < SCROLL) begin
         w_obs2_x_phys = respawn_x(r_lfsr[13:8], w_obs1_x_phys);
         w_obs2_h_phys = MIN_OBS_H + {5'd0, r_lfsr[10:8]};
      end else begin
         w_obs2_h_phys = r_obs2_h;
      end
   end

   assign w_hit = collides(w_obs1_x_phys, w_obs1_h_phys, w_dino_y_phys) ||
                  collides(w_obs2_x_phys, w_obs2_h_phys, w_dino_y_phys);

   // Next-state and next-datapath selection by game state
   always_comb begin
      w_state_n  = r_state;
      w_dino_y_n = r_dino_y;
      w_vel_n    = r_vel;
      w_obs1_x_n = r_obs1_x;
      w_obs1_h_n = r_obs1_h;
      w_obs2_x_n = r_obs2_x;
      w_obs2_h_n = r_obs2_h;
      w_score_n  = r_score;
      w_lfsr_n   = r_lfsr;
      case (r_state)
         GAME_MENU: begin
            if (r_jump_req) w_state_n = GAME_RUNNING;
            else            w_state_n = GAME_MENU;
         end
         GAME_RUNNING: begin
            if (r_pause_req) begin
               w_state_n = GAME_PAUSE;
            end else begin
               w_dino_y_n = w_dino_y_phys;
               w_vel_n    = w_vel_phys;
               w_obs1_x_n = w_obs1_x_phys;
               w_obs1_h_n = w_obs1_h_phys;
               w_obs2_x_n = w_obs2_x_phys;
               w_obs2_h_n = w_obs2_h_phys;
               w_lfsr_n   = lfsr_next(r_lfsr);
               if (w_hit) w_state_n = GAME_OVER;
               else       w_score_n = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
            end
         end
         GAME_PAUSE: begin
            if (r_pause_req) w_state_n = GAME_RUNNING;
            else             w_state_n = GAME_PAUSE;
         end
         GAME_OVER: begin
            if (r_jump_req) begin
               w_state_n  = GAME_MENU;
               w_dino_y_n = DINO_Y0;
               w_vel_n    = 8'sd0;
               w_obs1_x_n = OBS1_X0;
               w_obs1_h_n = MIN_OBS_H;
               w_obs2_x_n = OBS2_X0;
               w_obs2_h_n = MAX_OBS_H;
               w_score_n  = 16'd0;
            end else begin
               w_state_n = GAME_OVER;
            end
         end
         default: w_state_n = GAME_MENU;
      endcase
   end

   // Game-state register, advanced on the frame tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_state <= GAME_MENU;
      else if (w_tick) r_state <= w_state_n;
      else             r_state <= r_state;
   end

   // Frame strobe, button requests and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_clk <= 1'b0;
         r_jump_d    <= 1'b0;
         r_pause_d   <= 1'b0;
         r_jump_req  <= 1'b0;
         r_pause_req <= 1'b0;
         r_dino_y    <= DINO_Y0;
         r_vel       <= 8'sd0;
         r_obs1_x    <= OBS1_X0;
         r_obs1_h    <= MIN_OBS_H;
         r_obs2_x    <= OBS2_X0;
         r_obs2_h    <= MAX_OBS_H;
         r_score     <= 16'd0;
         r_lfsr      <= LFSR_SEED;
      end else begin
         r_frame_clk <= w_tick;
         r_jump_d    <= bus.btnJump;
         r_pause_d   <= bus.btnPause;
         // A press landing on the tick edge survives into the next frame
         r_jump_req  <= w_tick ? w_jump_rise  : (r_jump_req  | w_jump_rise);
         r_pause_req <= w_tick ? w_pause_rise : (r_pause_req | w_pause_rise);
         if (w_tick) begin
            r_dino_y <= w_dino_y_n;
            r_vel    <= w_vel_n;
            r_obs1_x <= w_obs1_x_n;
            r_obs1_h <= w_obs1_h_n;
            r_obs2_x <= w_obs2_x_n;
            r_obs2_h <= w_obs2_h_n;
            r_score  <= w_score_n;
            r_lfsr   <= w_lfsr_n;
         end
      end
   end

   assign bus.frameClk  = r_frame_clk;
   assign bus.gameState = r_state;
   assign bus.dinoY     = r_dino_y;
   assign bus.obs1X     = r_obs1_x;
   assign bus.obs1H     = r_obs1_h;
   assign bus.obs2X     = r_obs2_x;
   assign bus.obs2H     = r_obs2_h;
   assign bus.score     = r_score;
endmodule
